// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - byte-stream program loader and run-cycle controller for the 9-bit processor
module prog_loader #(
    parameter int IW        = 9,
    parameter int AW        = 10,
    parameter int CW        = 16,
    parameter int START_CYC = 2
) (
    input  logic          CLK,
    input  logic          reset,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          imem_we,
    output logic [AW-1:0] imem_addr,
    output logic [IW-1:0] imem_wdata,
    output logic          dut_start,
    input  logic          dut_halt,
    output logic          busy,
    output logic          done,
    output logic          timeout,
    output logic          len_err,
    output logic [CW-1:0] cycle_count
);

    typedef enum logic [2:0] {
        IDLE, LEN_HI, INS_LO, INS_HI, START, RUN, DONE
    } state_t;

    localparam int          SCW     = (START_CYC < 2) ? 1 : $clog2(START_CYC + 1);
    localparam logic [16:0] MAX_LEN = 17'(2 ** AW);
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    state_t          state_q, state_d;
    logic [7:0]      len_lo_q, len_lo_d;
    logic [7:0]      lo_q, lo_d;
    logic [AW-1:0]   last_q, last_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [SCW-1:0]  scnt_q, scnt_d;
    logic [CW-1:0]   count_q, count_d;
    logic            done_q, done_d;
    logic            timeout_q, timeout_d;
    logic            len_err_q, len_err_d;
    logic            imem_we_q, imem_we_d;
    logic [AW-1:0]   imem_addr_q, imem_addr_d;
    logic [IW-1:0]   imem_wdata_q, imem_wdata_d;
    logic            in_ready_q, in_ready_d;
    logic            dut_start_q, dut_start_d;
    logic            busy_q, busy_d;

    logic            accept;
    logic [16:0]     n_ext;

    assign accept = in_valid & in_ready_q;
    assign n_ext  = {1'b0, in_data, len_lo_q};

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_d      = state_q;
        len_lo_d     = len_lo_q;
        lo_d         = lo_q;
        last_d       = last_q;
        idx_d        = idx_q;
        scnt_d       = scnt_q;
        count_d      = count_q;
        done_d       = done_q;
        timeout_d    = timeout_q;
        len_err_d    = 1'b0;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;

        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    len_lo_d  = in_data;
                    done_d    = 1'b0;
                    timeout_d = 1'b0;
                    count_d   = '0;
                    state_d   = LEN_HI;
                end
            end
            LEN_HI: begin
                if (accept) begin
                    if (n_ext == 17'd0 || n_ext > MAX_LEN) begin
                        len_err_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        last_d  = AW'(n_ext - 17'd1);
                        idx_d   = '0;
                        state_d = INS_LO;
                    end
                end
            end
            INS_LO: begin
                if (accept) begin
                    lo_d    = in_data;
                    state_d = INS_HI;
                end
            end
            INS_HI: begin
                if (accept) begin
                    imem_we_d    = 1'b1;
                    imem_addr_d  = idx_q;
                    imem_wdata_d = IW'({in_data[0], lo_q});
                    idx_d        = idx_q + 1'b1;
                    if (idx_q == last_q) begin
                        scnt_d  = '0;
                        state_d = START;
                    end else begin
                        state_d = INS_LO;
                    end
                end
            end
            START: begin
                // First START cycle carries the final write; START_CYC more follow it
                if (scnt_q == SCW'(START_CYC)) begin
                    state_d = RUN;
                end else begin
                    scnt_d = scnt_q + 1'b1;
                end
            end
            RUN: begin
                if (dut_halt) begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    count_d = count_q + 1'b1;
                    if (count_d == CNT_MAX) begin
                        done_d    = 1'b1;
                        timeout_d = 1'b1;
                        state_d   = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = !(state_d == START || state_d == RUN);
        dut_start_d = !(state_d == RUN || state_d == DONE);
        busy_d      = !(state_d == IDLE || state_d == DONE);
    end

    // State and output registers; reset returns to IDLE with the processor held
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q      <= IDLE;
            len_lo_q     <= '0;
            lo_q         <= '0;
            last_q       <= '0;
            idx_q        <= '0;
            scnt_q       <= '0;
            count_q      <= '0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
            len_err_q    <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            in_ready_q   <= 1'b1;
            dut_start_q  <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_lo_q     <= len_lo_d;
            lo_q         <= lo_d;
            last_q       <= last_d;
            idx_q        <= idx_d;
            scnt_q       <= scnt_d;
            count_q      <= count_d;
            done_q       <= done_d;
            timeout_q    <= timeout_d;
            len_err_q    <= len_err_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            in_ready_q   <= in_ready_d;
            dut_start_q  <= dut_start_d;
            busy_q       <= busy_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign imem_we     = imem_we_q;
    assign imem_addr   = imem_addr_q;
    assign imem_wdata  = imem_wdata_q;
    assign dut_start   = dut_start_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout     = timeout_q;
    assign len_err     = len_err_q;
    assign cycle_count = count_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - directed self-checking bench for prog_loader
module tb_prog_loader;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic reset;

    logic [7:0]  in_data;
    logic        in_valid, in_ready, imem_we, dut_start, dut_halt;
    logic        busy, done, timeout, len_err;
    logic [9:0]  imem_addr;
    logic [8:0]  imem_wdata;
    logic [15:0] cycle_count;

    logic [7:0]  in_data_b;
    logic        in_valid_b, in_ready_b, imem_we_b, dut_start_b, dut_halt_b;
    logic        busy_b, done_b, timeout_b, len_err_b;
    logic [9:0]  imem_addr_b;
    logic [8:0]  imem_wdata_b;
    logic [3:0]  cycle_count_b;

    prog_loader #(.IW(9), .AW(10), .CW(16), .START_CYC(2)) u_dut (
        .CLK(CLK), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .dut_start(dut_start), .dut_halt(dut_halt),
        .busy(busy), .done(done), .timeout(timeout), .len_err(len_err),
        .cycle_count(cycle_count)
    );

    prog_loader #(.IW(9), .AW(10), .CW(4), .START_CYC(2)) u_dut_b (
        .CLK(CLK), .reset(reset), .in_data(in_data_b), .in_valid(in_valid_b),
        .in_ready(in_ready_b), .imem_we(imem_we_b), .imem_addr(imem_addr_b),
        .imem_wdata(imem_wdata_b), .dut_start(dut_start_b), .dut_halt(dut_halt_b),
        .busy(busy_b), .done(done_b), .timeout(timeout_b), .len_err(len_err_b),
        .cycle_count(cycle_count_b)
    );

    int n_run  = 0;
    int n_fail = 0;

    int         wr_n = 0;
    logic [9:0] wa [64];
    logic [8:0] wd [64];

    // Record every imem write of the main instance
    always @(negedge CLK) begin
        if (imem_we === 1'b1) begin
            if (wr_n < 64) begin
                wa[wr_n] = imem_addr;
                wd[wr_n] = imem_wdata;
            end
            wr_n = wr_n + 1;
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input bit sel, input logic [7:0] b, input int gaps);
        int guard;
        repeat (gaps) step();
        if (sel) begin
            in_data_b = b; in_valid_b = 1'b1;
        end else begin
            in_data = b; in_valid = 1'b1;
        end
        guard = 0;
        while (((sel ? in_ready_b : in_ready) !== 1'b1) && guard < 100) begin
            step();
            guard++;
        end
        if (guard >= 100) begin
            n_fail++;
            $display("FAIL send_wait: in_ready stayed %b, required 1", sel ? in_ready_b : in_ready);
        end
        step();
        in_valid = 1'b0;
        in_valid_b = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        n_run++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b need 1", in_ready); end
        n_run++; if (dut_start !== 1'b1) begin n_fail++; $display("FAIL rst_dut_start: got %b need 1", dut_start); end
        n_run++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b need 0", done); end
        n_run++; if (imem_we !== 1'b0) begin n_fail++; $display("FAIL rst_imem_we: got %b need 0", imem_we); end
        n_run++; if (cycle_count !== 16'd0) begin n_fail++; $display("FAIL rst_count: got %0d need 0", cycle_count); end
        n_run++; if (busy !== 1'b0 || timeout !== 1'b0 || len_err !== 1'b0) begin
            n_fail++; $display("FAIL rst_flags: busy=%b timeout=%b len_err=%b need 000", busy, timeout, len_err); end
        n_run++; if (imem_addr !== 10'd0 || imem_wdata !== 9'd0) begin
            n_fail++; $display("FAIL rst_imem_bus: addr=%h data=%h need 0/0", imem_addr, imem_wdata); end
        n_run++; if (in_ready_b !== 1'b1 || dut_start_b !== 1'b1) begin
            n_fail++; $display("FAIL rst_b: in_ready=%b dut_start=%b need 1/1", in_ready_b, dut_start_b); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_load();
        logic [7:0] bytes [8];
        logic [8:0] exp_d [3];
        int w0;
        bytes = '{8'h03, 8'h00, 8'hAB, 8'h01, 8'h03, 8'hFE, 8'h00, 8'h01};
        exp_d = '{9'h1AB, 9'h003, 9'h100};
        w0 = wr_n;
        for (int i = 0; i < 8; i++) send(1'b0, bytes[i], int'($urandom_range(0, 2)));
        n_run++; if (imem_we !== 1'b1 || imem_addr !== 10'd2) begin
            n_fail++; $display("FAIL load_last_we: we=%b addr=%0d need 1/2", imem_we, imem_addr); end
        for (int k = 1; k <= 2; k++) begin
            step();
            n_run++; if (dut_start !== 1'b1 || imem_we !== 1'b0) begin
                n_fail++; $display("FAIL load_start_hold%0d: dut_start=%b we=%b need 1/0", k, dut_start, imem_we); end
        end
        step();
        n_run++; if (dut_start !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL load_run_entry: dut_start=%b in_ready=%b busy=%b need 0/0/1", dut_start, in_ready, busy); end
        n_run++; if (wr_n - w0 !== 3) begin n_fail++; $display("FAIL load_wr_count: got %0d need 3", wr_n - w0); end
        for (int i = 0; i < 3; i++) begin
            n_run++; if (wa[w0+i] !== 10'(i) || wd[w0+i] !== exp_d[i]) begin
                n_fail++; $display("FAIL load_wr%0d: addr=%0d data=%h need %0d/%h", i, wa[w0+i], wd[w0+i], i, exp_d[i]); end
        end
    endtask

    task automatic test_halt();
        dut_halt = 1'b0;
        repeat (25) step();
        n_run++; if (cycle_count !== 16'd25 || done !== 1'b0) begin
            n_fail++; $display("FAIL halt_pre: count=%0d done=%b need 25/0", cycle_count, done); end
        dut_halt = 1'b1;
        step();
        dut_halt = 1'b0;
        n_run++; if (cycle_count !== 16'd25) begin n_fail++; $display("FAIL halt_count: got %0d need 25", cycle_count); end
        n_run++; if (done !== 1'b1 || timeout !== 1'b0) begin
            n_fail++; $display("FAIL halt_done: done=%b timeout=%b need 1/0", done, timeout); end
        n_run++; if (in_ready !== 1'b1 || dut_start !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL halt_outs: in_ready=%b dut_start=%b busy=%b need 1/0/0", in_ready, dut_start, busy); end
        step();
        n_run++; if (done !== 1'b1 || cycle_count !== 16'd25) begin
            n_fail++; $display("FAIL halt_hold: done=%b count=%0d need 1/25", done, cycle_count); end
    endtask

    task automatic test_len_err();
        int w0;
        w0 = wr_n;
        send(1'b0, 8'h00, 0);
        n_run++; if (done !== 1'b0 || dut_start !== 1'b1 || busy !== 1'b1 || cycle_count !== 16'd0) begin
            n_fail++; $display("FAIL restart: done=%b dut_start=%b busy=%b count=%0d need 0/1/1/0", done, dut_start, busy, cycle_count); end
        send(1'b0, 8'h00, 0);
        n_run++; if (len_err !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL len_zero: len_err=%b busy=%b in_ready=%b need 1/0/1", len_err, busy, in_ready); end
        step();
        n_run++; if (len_err !== 1'b0) begin n_fail++; $display("FAIL len_pulse: got %b need 0", len_err); end
        send(1'b0, 8'h01, 0);
        send(1'b0, 8'h04, 0);
        n_run++; if (len_err !== 1'b1 || busy !== 1'b0 || dut_start !== 1'b1) begin
            n_fail++; $display("FAIL len_big: len_err=%b busy=%b dut_start=%b need 1/0/1", len_err, busy, dut_start); end
        step();
        n_run++; if (len_err !== 1'b0 || wr_n !== w0) begin
            n_fail++; $display("FAIL len_nowrite: len_err=%b writes=%0d need 0/0", len_err, wr_n - w0); end
        send(1'b0, 8'h00, 0);
        send(1'b0, 8'h04, 0);
        n_run++; if (len_err !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL len_max_ok: len_err=%b busy=%b need 0/1", len_err, busy); end
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_mid_reset();
        int w0;
        w0 = wr_n;
        send(1'b0, 8'h02, 0); send(1'b0, 8'h00, 0);
        send(1'b0, 8'h11, 0); send(1'b0, 8'h00, 0);
        send(1'b0, 8'h22, 0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_run++; if (busy !== 1'b0 || dut_start !== 1'b1 || in_ready !== 1'b1 || imem_we !== 1'b0) begin
            n_fail++; $display("FAIL rst_inshi: busy=%b dut_start=%b in_ready=%b we=%b need 0/1/1/0", busy, dut_start, in_ready, imem_we); end
        repeat (3) step();
        n_run++; if (wr_n - w0 !== 1) begin n_fail++; $display("FAIL rst_inshi_writes: got %0d need 1", wr_n - w0); end
        send(1'b0, 8'h01, 0); send(1'b0, 8'h00, 0);
        send(1'b0, 8'h55, 0); send(1'b0, 8'h01, 0);
        n_run++; if (imem_we !== 1'b1 || imem_addr !== 10'd0 || imem_wdata !== 9'h155) begin
            n_fail++; $display("FAIL reload1: we=%b addr=%0d data=%h need 1/0/155", imem_we, imem_addr, imem_wdata); end
        repeat (8) step();
        n_run++; if (dut_start !== 1'b0 || cycle_count !== 16'd5) begin
            n_fail++; $display("FAIL pre_rst_run: dut_start=%b count=%0d need 0/5", dut_start, cycle_count); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_run++; if (dut_start !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || cycle_count !== 16'd0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL rst_run: dut_start=%b busy=%b done=%b count=%0d in_ready=%b need 1/0/0/0/1",
                dut_start, busy, done, cycle_count, in_ready); end
        send(1'b0, 8'h01, 0); send(1'b0, 8'h00, 0);
        send(1'b0, 8'h77, 0); send(1'b0, 8'h00, 0);
        n_run++; if (imem_we !== 1'b1 || imem_addr !== 10'd0 || imem_wdata !== 9'h077) begin
            n_fail++; $display("FAIL reload2: we=%b addr=%0d data=%h need 1/0/077", imem_we, imem_addr, imem_wdata); end
    endtask

    task automatic test_timeout();
        send(1'b1, 8'h01, 0); send(1'b1, 8'h00, 0);
        send(1'b1, 8'hAA, 0); send(1'b1, 8'h00, 0);
        repeat (17) step();
        n_run++; if (done_b !== 1'b0 || cycle_count_b !== 4'd14) begin
            n_fail++; $display("FAIL to_pre: done=%b count=%0d need 0/14", done_b, cycle_count_b); end
        step();
        n_run++; if (done_b !== 1'b1 || timeout_b !== 1'b1 || cycle_count_b !== 4'd15 || dut_start_b !== 1'b0) begin
            n_fail++; $display("FAIL to_done: done=%b timeout=%b count=%0d dut_start=%b need 1/1/15/0",
                done_b, timeout_b, cycle_count_b, dut_start_b); end
        step();
        n_run++; if (done_b !== 1'b1 || timeout_b !== 1'b1) begin
            n_fail++; $display("FAIL to_hold: done=%b timeout=%b need 1/1", done_b, timeout_b); end
        send(1'b1, 8'h05, 0);
        n_run++; if (done_b !== 1'b0 || timeout_b !== 1'b0 || cycle_count_b !== 4'd0 || dut_start_b !== 1'b1 || busy_b !== 1'b1) begin
            n_fail++; $display("FAIL to_clear: done=%b timeout=%b count=%0d dut_start=%b busy=%b need 0/0/0/1/1",
                done_b, timeout_b, cycle_count_b, dut_start_b, busy_b); end
    endtask

    initial begin
        reset = 1'b1;
        in_data = 8'h00; in_valid = 1'b0; dut_halt = 1'b0;
        in_data_b = 8'h00; in_valid_b = 1'b0; dut_halt_b = 1'b0;
        test_reset();
        test_load();
        test_halt();
        test_len_err();
        test_mid_reset();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
